dfr_matrix_multiply: RTL and testbench
======================================

Name: dfr_matrix_multiply

Overview:
- Responder side of the DFR core's matrix-multiply handshake: accepts a one-cycle start pulse and holds busy until the product is fully written.
- Computes Z = X * Y, where X is X_ROWS x X_COLS_Y_ROWS and Y is X_COLS_Y_ROWS x Y_COLS.
  - X is reservoir output, read from a RAM.
  - Y is the output weights, read from a second RAM.
- Writes Z into an output RAM for host readback.
- Sits between the reservoir/weight memories and the output memory, driven by the DFR core controller.

Parameters:
ADDR_WIDTH, 32, width of all RAM address ports
DATA_WIDTH, 32, width of signed two's-complement data words
X_ROWS, 5, rows of X and of Z
Y_COLS, 5, columns of Y and of Z
X_COLS_Y_ROWS, 5, shared inner dimension K; must be >= 1
X_BASE, 0, base address of X, row-major
Y_BASE, 0, base address of Y, row-major
Z_BASE, 0, base address of Z, row-major

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle start pulse from controller
busy  out  1  high while multiply in progress
x_addr  out  ADDR_WIDTH  X RAM read address
x_rd_en  out  1  X RAM read enable
x_data  in  DATA_WIDTH  X RAM read data, 1-cycle latency
y_addr  out  ADDR_WIDTH  Y RAM read address
y_rd_en  out  1  Y RAM read enable
y_data  in  DATA_WIDTH  Y RAM read data, 1-cycle latency
z_addr  out  ADDR_WIDTH  Z RAM write address
z_we  out  1  Z RAM write enable
z_data  out  DATA_WIDTH  Z RAM write data

Behaviour:
- Reset state: all outputs 0; state IDLE; counters i, j, k = 0; accumulator = 0; read-valid delay flag = 0.
- Reset mid-operation aborts immediately. No further writes are issued.
- FSM states:
  - IDLE: busy=0. On a clock edge with start=1: i=j=k=0, acc=0, busy<=1, go to FETCH.
    - busy is therefore high in the first cycle after start, which the controller samples.
  - FETCH: x_rd_en=y_rd_en=1.
    - x_addr = X_BASE + i*K + k; y_addr = Y_BASE + k*Y_COLS + j. Addresses are combinational from the counters.
    - k increments each cycle; when k==K-1, go to DRAIN.
  - DRAIN: one cycle, no reads issued; go to WRITE.
  - WRITE: z_we=1; z_addr = Z_BASE + i*Y_COLS + j; z_data = result(acc).
    - Clear acc and set k=0.
    - Advance j; when j==Y_COLS-1, set j=0 and increment i.
    - If (i,j) was the last element, go to IDLE and busy<=0 at this edge; otherwise go to FETCH.
- MAC rule: rd_valid is x_rd_en delayed one cycle. When rd_valid=1, acc <= acc + x_data*y_data.
  - Product is full signed 2*DATA_WIDTH.
  - acc is 2*DATA_WIDTH + $clog2(K) + 1 bits and never overflows internally.
- Result: low DATA_WIDTH bits of acc (wrap).
- Latency:
  - K+2 cycles per output element.
  - busy is high for exactly X_ROWS*Y_COLS*(K+2) cycles; defaults give 175.
- start while busy is ignored and has no effect on counters.
- Writes are strictly row-major in order (0,0),(0,1)…; exactly one z_we per element.
- Read and write enables are never asserted in IDLE.

Optional Feature:
- Macro: DFR_MATMUL_SATURATE_EN.
- Defined: result clamps acc to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: result truncates to the low DATA_WIDTH bits.
- Timing and latency are identical in both builds.

Decomposition:
- Package dfr_matmul_pkg contains:
  - state enum (IDLE, FETCH, DRAIN, WRITE);
  - function acc_width(DATA_WIDTH, K);
  - saturate/truncate function.
- Sub-module dfr_mac_unit: signed multiply-accumulate.
  - Inputs: clk, rst, clr, en, a, b. Output: acc.
  - Instantiated once; the FSM and address counters stay in the top module.

Test Plan:
1. Defaults; X = identity padded to 5x5, Y(r,c) = 10*r + c.
   - Z == Y at all 25 addresses.
   - busy high exactly 175 cycles; busy already high in the first cycle after start.
2. All X = 1, all Y = 1.
   - Every Z = 5.
   - z_we pulses at cycles 7, 14, … 175 after start, with addresses 0…24 in order.
3. X = -3, Y = 7 everywhere.
   - Every Z = -105 (0xFFFFFF97).
4. X = 0x7FFFFFFF, Y = 2.
   - With DFR_MATMUL_SATURATE_EN: every Z = 0x7FFFFFFF.
   - Without: every Z = 0xFFFFFFF6.
5. start re-pulsed at cycles 20 and 100 during a run.
   - No restart; write sequence and 175-cycle busy are unchanged.
6. rst asserted at cycle 50 for 2 cycles.
   - busy and z_we drop immediately; no further writes.
   - A fresh start afterwards produces the complete correct result.

Source files
------------

// File: rtl/dfr_matmul_pkg.sv
// ---------------------------------------------------------------------------
// dfr_matmul_pkg
// Shared types and helpers for the DFR matrix-multiply block.
//   state_t      : sequencer states (IDLE, FETCH, DRAIN, WRITE)
//   MAX_W        : widest accumulator the result helper can handle
//   acc_width()  : accumulator width that cannot overflow for a K-term sum
//   result_word(): reduces the wide accumulator to a DATA_WIDTH result
// Build option: define DFR_MATMUL_SATURATE_EN to clamp results to the signed
// DATA_WIDTH range; otherwise results wrap (low DATA_WIDTH bits kept).
// ---------------------------------------------------------------------------
package dfr_matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int MAX_W = 128;

    // Full-width products plus log2(K)+1 growth bits for the K-term sum.
    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k) + 1;
    endfunction

    // Caller keeps the low dw bits of the returned word.
    function automatic logic [MAX_W-1:0] result_word(input logic signed [MAX_W-1:0] acc,
                                                     input int dw);
`ifdef DFR_MATMUL_SATURATE_EN
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        one = MAX_W'(1);
        hi  = (one <<< (dw - 1)) - one;
        lo  = ~hi;
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end else begin
            return acc;
        end
`else
        logic [MAX_W-1:0] mask;
        mask = ~({MAX_W{1'b1}} << dw);
        return acc & mask;
`endif
    endfunction

endpackage

// File: rtl/dfr_matmul_mac.sv
// ---------------------------------------------------------------------------
// dfr_mac_unit
// Signed multiply-accumulate register for one output element.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator (has priority over en)
//   en       : add a*b into the accumulator this cycle
//   a, b     : signed DATA_WIDTH operands
//   acc      : signed ACC_WIDTH running sum
// ---------------------------------------------------------------------------
module dfr_mac_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 68
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    // Operands are sign-extended first so the product is the exact signed value.
    assign prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

    // Accumulator register; the product is sign-extended into the wide sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + ACC_WIDTH'(prod);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dfr_matrix_multiply.sv
// ---------------------------------------------------------------------------
// dfr_matrix_multiply
// Computes Z = X * Y (X: X_ROWS x K, Y: K x Y_COLS, row-major in RAM) and
// writes Z row-major to the output RAM. One start pulse launches a run; busy
// stays high until the last element is written. Each element takes K fetch
// cycles, one drain cycle for the 1-cycle RAM latency, and one write cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   start / busy      : controller handshake
//   x_addr/x_rd_en/x_data : X RAM read port
//   y_addr/y_rd_en/y_data : Y RAM read port
//   z_addr/z_we/z_data    : Z RAM write port
// Build option: DFR_MATMUL_SATURATE_EN selects clamping instead of wrapping.
// ---------------------------------------------------------------------------
module dfr_matrix_multiply
    import dfr_matmul_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int X_ROWS        = 5,
    parameter int Y_COLS        = 5,
    parameter int X_COLS_Y_ROWS = 5,
    parameter int X_BASE        = 0,
    parameter int Y_BASE        = 0,
    parameter int Z_BASE        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic                  x_rd_en,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  y_rd_en,
    input  logic [DATA_WIDTH-1:0] y_data,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic                  z_we,
    output logic [DATA_WIDTH-1:0] z_data
);

    localparam int K     = X_COLS_Y_ROWS;
    localparam int ACC_W = acc_width(DATA_WIDTH, K);

    localparam logic [ADDR_WIDTH-1:0] K_A    = ADDR_WIDTH'(K);
    localparam logic [ADDR_WIDTH-1:0] YC_A   = ADDR_WIDTH'(Y_COLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(K - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_J = ADDR_WIDTH'(Y_COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(X_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    i_q, i_d;
    logic [ADDR_WIDTH-1:0]    j_q, j_d;
    logic [ADDR_WIDTH-1:0]    k_q, k_d;
    logic                     busy_q, busy_d;
    logic                     rd_valid_q;
    logic                     acc_clr;
    logic signed [ACC_W-1:0]  acc;

    // The MAC adds whenever read data returned from last cycle's fetch.
    dfr_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (rd_valid_q),
        .a   (x_data),
        .b   (y_data),
        .acc (acc)
    );

    // State, counters and the read-valid delay; reset aborts any run at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            rd_valid_q <= x_rd_en;
        end
    end

    // Next-state, counter advance and RAM port drive. Start is only honoured in
    // IDLE, so a stray pulse mid-run never disturbs the counters.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        busy_d  = busy_q;
        acc_clr = 1'b0;
        x_rd_en = 1'b0;
        y_rd_en = 1'b0;
        z_we    = 1'b0;
        x_addr  = '0;
        y_addr  = '0;
        z_addr  = '0;
        z_data  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                x_rd_en = 1'b1;
                y_rd_en = 1'b1;
                x_addr  = ADDR_WIDTH'(X_BASE) + i_q * K_A + k_q;
                y_addr  = ADDR_WIDTH'(Y_BASE) + k_q * YC_A + j_q;
                if (k_q == LAST_K) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + ONE_A;
                end
            end
            DRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                z_we    = 1'b1;
                z_addr  = ADDR_WIDTH'(Z_BASE) + i_q * YC_A + j_q;
                z_data  = DATA_WIDTH'(result_word(MAX_W'(acc), DATA_WIDTH));
                acc_clr = 1'b1;
                k_d     = '0;
                if (j_q == LAST_J) begin
                    j_d = '0;
                    if (i_q == LAST_I) begin
                        i_d     = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        i_d     = i_q + ONE_A;
                        state_d = FETCH;
                    end
                end else begin
                    j_d     = j_q + ONE_A;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_dfr_matrix_multiply.sv
// ---------------------------------------------------------------------------
// tb_dfr_matrix_multiply
// Directed bench for dfr_matrix_multiply at default parameters (5x5x5).
// Models the X/Y RAMs with 1-cycle read latency and captures Z writes.
// ---------------------------------------------------------------------------
module tb_dfr_matrix_multiply;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] x_addr, y_addr, z_addr;
    logic        x_rd_en, y_rd_en, z_we;
    logic [31:0] x_data = 32'h0;
    logic [31:0] y_data = 32'h0;
    logic [31:0] z_data;

    logic [31:0] xMem [0:24];
    logic [31:0] yMem [0:24];
    logic [31:0] zMem [0:24];
    logic [31:0] wrAddr [0:63];
    int          wrCyc [0:63];
    int          nWr;
    int          busyCyc;
    int          idleViol;
    logic        firstBusy;
    int          total = 0;
    int          bad = 0;

    dfr_matrix_multiply dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .x_addr  (x_addr),
        .x_rd_en (x_rd_en),
        .x_data  (x_data),
        .y_addr  (y_addr),
        .y_rd_en (y_rd_en),
        .y_data  (y_data),
        .z_addr  (z_addr),
        .z_we    (z_we),
        .z_data  (z_data)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Synchronous-read RAM models with one cycle of latency.
    always @(posedge clk) begin
        x_data <= (x_rd_en && x_addr < 32'd25) ? xMem[x_addr] : 32'h0;
        y_data <= (y_rd_en && y_addr < 32'd25) ? yMem[y_addr] : 32'h0;
    end

    // One comparison: counted, asserted, failure reported with both values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fill X and Y: mode 0 identity/10r+c, 1 all ones, 2 -3/7, 3 max/2.
    task automatic loadMem(input int mode);
        for (int n = 0; n < 25; n++) begin
            case (mode)
                0: begin
                    xMem[n] = ((n / 5) == (n % 5)) ? 32'd1 : 32'd0;
                    yMem[n] = 32'(10 * (n / 5) + (n % 5));
                end
                1: begin xMem[n] = 32'd1;          yMem[n] = 32'd1; end
                2: begin xMem[n] = 32'hFFFFFFFD;   yMem[n] = 32'd7; end
                default: begin xMem[n] = 32'h7FFFFFFF; yMem[n] = 32'd2; end
            endcase
            zMem[n] = 32'hDEADBEEF;
        end
    endtask

    // Pulse start, then watch 200 cycles at the falling edge, recording busy
    // time and every write. Optional extra start pulses and a reset window.
    task automatic applyStimulus(input int pulseA, input int pulseB, input int rstAt);
        busyCyc  = 0;
        nWr      = 0;
        idleViol = 0;
        firstBusy = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c == 1) firstBusy = busy;
            if (busy) busyCyc++;
            if (!busy && (x_rd_en || y_rd_en || z_we)) idleViol++;
            if (z_we && nWr < 64) begin
                if (z_addr < 32'd25) zMem[z_addr] = z_data;
                wrAddr[nWr] = z_addr;
                wrCyc[nWr]  = c;
                nWr++;
            end
            start = (c == pulseA || c == pulseB);
            if (c == rstAt) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_busy_drop", {31'b0, busy}, 32'd0);
                checkOutput("rst_we_drop", {31'b0, z_we}, 32'd0);
            end
            if (c == rstAt + 2) rst = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_xen", {31'b0, x_rd_en}, 32'd0);
        checkOutput("rst_yen", {31'b0, y_rd_en}, 32'd0);
        checkOutput("rst_we", {31'b0, z_we}, 32'd0);
        checkOutput("rst_xaddr", x_addr, 32'd0);
        checkOutput("rst_zdata", z_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: identity times Y gives Y back; 175 busy cycles
        loadMem(0);
        applyStimulus(-1, -1, -1);
        checkOutput("t1_busy_first", {31'b0, firstBusy}, 32'd1);
        checkOutput("t1_busy_cycles", busyCyc, 32'd175);
        checkOutput("t1_nwr", nWr, 32'd25);
        checkOutput("t1_idle_en", idleViol, 32'd0);
        for (int n = 0; n < 25; n++)
            checkOutput($sformatf("t1_z[%0d]", n), zMem[n], 32'(10 * (n / 5) + (n % 5)));

        // 2: all ones, K=5 so every Z is 5; write timing 7,14,...,175
        loadMem(1);
        applyStimulus(-1, -1, -1);
        checkOutput("t2_nwr", nWr, 32'd25);
        for (int n = 0; n < 25; n++) begin
            checkOutput($sformatf("t2_addr[%0d]", n), wrAddr[n], 32'(n));
            checkOutput($sformatf("t2_cyc[%0d]", n), wrCyc[n], 32'(7 * (n + 1)));
            checkOutput($sformatf("t2_z[%0d]", n), zMem[n], 32'd5);
        end

        // 3: 5 * (-3 * 7) = -105
        loadMem(2);
        applyStimulus(-1, -1, -1);
        for (int n = 0; n < 25; n++)
            checkOutput($sformatf("t3_z[%0d]", n), zMem[n], 32'hFFFFFF97);

        // 4: 5 * 2 * 0x7FFFFFFF = 0x4_FFFFFFF6 overflows DATA_WIDTH
        loadMem(3);
        applyStimulus(-1, -1, -1);
        for (int n = 0; n < 25; n++)
`ifdef DFR_MATMUL_SATURATE_EN
            checkOutput($sformatf("t4_z[%0d]", n), zMem[n], 32'h7FFFFFFF);
`else
            checkOutput($sformatf("t4_z[%0d]", n), zMem[n], 32'hFFFFFFF6);
`endif

        // 5: start re-pulsed mid-run is ignored
        loadMem(0);
        applyStimulus(20, 100, -1);
        checkOutput("t5_busy_cycles", busyCyc, 32'd175);
        checkOutput("t5_nwr", nWr, 32'd25);
        for (int n = 0; n < 25; n++) begin
            checkOutput($sformatf("t5_addr[%0d]", n), wrAddr[n], 32'(n));
            checkOutput($sformatf("t5_cyc[%0d]", n), wrCyc[n], 32'(7 * (n + 1)));
            checkOutput($sformatf("t5_z[%0d]", n), zMem[n], 32'(10 * (n / 5) + (n % 5)));
        end

        // 6: reset at cycle 50 aborts after 7 writes; a fresh run completes
        loadMem(1);
        applyStimulus(-1, -1, 50);
        checkOutput("t6_busy_cycles", busyCyc, 32'd50);
        checkOutput("t6_nwr", nWr, 32'd7);
        loadMem(0);
        applyStimulus(-1, -1, -1);
        checkOutput("t6_rerun_busy", busyCyc, 32'd175);
        checkOutput("t6_rerun_nwr", nWr, 32'd25);
        for (int n = 0; n < 25; n++)
            checkOutput($sformatf("t6_z[%0d]", n), zMem[n], 32'(10 * (n / 5) + (n % 5)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
